// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared types and default constants for the instruction memory controller
package imem_ctrl_pkg;

  localparam int unsigned IMEM_ADDR_W   = 5;
  localparam int unsigned IMEM_DATA_W   = 32;
  localparam int unsigned IMEM_RESET_PC = 0;

  typedef logic [IMEM_ADDR_W-1:0] pc_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    VALID = 2'd2
  } state_e;

  // Sequential pc advance; the natural width overflow gives the 31 -> 0 wrap.
  function automatic pc_t pc_next(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/imem_controller_if.sv
// rtl/imem_controller_if.sv - load, redirect, instruction stream and memory signals of the controller
interface imem_controller_if
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) ();

  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              reload;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] instr_pc;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;

  // Controller side.
  modport slave (
    input  load_valid, load_addr, load_data, load_last,
    input  reload, redirect_valid, redirect_pc, instr_ready, mem_rdata,
    output load_ready, instr_valid, instr_pc, instr_data,
    output mem_addr, mem_wdata, mem_rd
  );

  // Environment side: program loader, core and memory response.
  modport master (
    output load_valid, load_addr, load_data, load_last,
    output reload, redirect_valid, redirect_pc, instr_ready, mem_rdata,
    input  load_ready, instr_valid, instr_pc, instr_data,
    input  mem_addr, mem_wdata, mem_rd
  );

endinterface

// File: rtl/imem_prefetch_buf.sv
// rtl/imem_prefetch_buf.sv - one-entry prefetch register (data + pc) with valid and flush
module imem_prefetch_buf
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] pc_q;

  // Flush beats fill so a redirect or consumed entry never leaves a stale word behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - 2^ADDR_W x DATA_W memory, write on clock when rd is low, combinational read
module instruction_memory #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // A write lands at the clock edge of every cycle in which rd is low.
  always_ff @(posedge clk) begin
    if (!rd_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rd_i ? mem_q[addr_i] : '0;

endmodule

// File: rtl/imem_controller.sv
// rtl/imem_controller.sv - load/fetch sequencer for the instruction memory; IMEM_CTRL_PREFETCH_EN adds a one-entry prefetch buffer
module imem_controller
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned DATA_W   = IMEM_DATA_W,
  parameter int unsigned RESET_PC = IMEM_RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_controller_if.slave bus
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              mem_rd_c;
  logic              load_ready_c;
  logic              handshake;

  assign handshake = instr_valid_q & bus.instr_ready;

`ifdef IMEM_CTRL_PREFETCH_EN
  logic              pf_fill;
  logic              pf_flush;
  logic              pf_valid;
  logic [DATA_W-1:0] pf_data;
  logic [ADDR_W-1:0] pf_pc;

  // The buffer only ever holds the word at pc+1 while an instruction is being presented;
  // it empties whenever that word is consumed or the stream is redirected/reloaded.
  assign pf_fill  = (state_q == VALID) & ~pf_valid;
  assign pf_flush = (state_q != VALID) | bus.reload | bus.redirect_valid | handshake;

  imem_prefetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_prefetch_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .fill_i  (pf_fill),
    .flush_i (pf_flush),
    .data_i  (bus.mem_rdata),
    .pc_i    (pc_q + PC_ONE),
    .valid_o (pf_valid),
    .data_o  (pf_data),
    .pc_o    (pf_pc)
  );
`endif

  // Next state, memory drive and presented-instruction update; reload > redirect > handshake.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    instr_data_d  = instr_data_q;
    instr_pc_d    = instr_pc_q;
    mem_addr_c    = '0;
    mem_wdata_c   = '0;
    mem_rd_c      = 1'b1;
    load_ready_c  = 1'b0;

    case (state_q)
      LOAD: begin
        load_ready_c = 1'b1;
        if (bus.load_valid) begin
          mem_addr_c  = bus.load_addr;
          mem_wdata_c = bus.load_data;
          mem_rd_c    = 1'b0;
          if (bus.load_last) begin
            pc_d    = PC_RST;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        mem_addr_c = pc_q;
        if (bus.reload) begin
          state_d       = LOAD;
          instr_valid_d = 1'b0;
        end else if (bus.redirect_valid) begin
          pc_d          = bus.redirect_pc;
          instr_valid_d = 1'b0;
        end else begin
          instr_data_d  = bus.mem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = VALID;
        end
      end

      VALID: begin
`ifdef IMEM_CTRL_PREFETCH_EN
        mem_addr_c = pc_q + PC_ONE;
`else
        mem_addr_c = pc_q;
`endif
        if (bus.reload) begin
          state_d       = LOAD;
          instr_valid_d = 1'b0;
        end else if (bus.redirect_valid) begin
          pc_d          = bus.redirect_pc;
          instr_valid_d = 1'b0;
          state_d       = ISSUE;
        end else if (handshake) begin
          pc_d = pc_q + PC_ONE;
`ifdef IMEM_CTRL_PREFETCH_EN
          // Bypass the memory read of this cycle when the buffer has not caught it yet.
          instr_data_d  = pf_valid ? pf_data : bus.mem_rdata;
          instr_pc_d    = pf_valid ? pf_pc : (pc_q + PC_ONE);
          instr_valid_d = 1'b1;
`else
          instr_valid_d = 1'b0;
          state_d       = ISSUE;
`endif
        end
      end

      default: begin
        state_d       = LOAD;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State and presented-instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      pc_q          <= PC_RST;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      instr_data_q  <= instr_data_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // Reset overrides the combinational memory drive so a load word offered during reset never writes.
  assign bus.mem_rd      = mem_rd_c | ~rst_n;
  assign bus.mem_addr    = rst_n ? mem_addr_c : '0;
  assign bus.mem_wdata   = rst_n ? mem_wdata_c : '0;
  assign bus.load_ready  = load_ready_c;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_data  = instr_data_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_imem_controller.sv
// tb/tb_imem_controller.sv - scoreboard bench for imem_controller with an instruction_memory on the mem port
module tb_imem_controller;
  import imem_ctrl_pkg::*;

  localparam int unsigned AW = IMEM_ADDR_W;
  localparam int unsigned DW = IMEM_DATA_W;
`ifdef IMEM_CTRL_PREFETCH_EN
  localparam int EXP_HS = 8;
`else
  localparam int EXP_HS = 4;
`endif

  typedef struct {
    pc_t         pc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  imem_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_controller #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (IMEM_RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instruction_memory #(.ADDR_W(AW), .DATA_W(DW)) u_mem (
    .clk     (clk),
    .rd_i    (bus.mem_rd),
    .addr_i  (bus.mem_addr),
    .wdata_i (bus.mem_wdata),
    .rdata_o (bus.mem_rdata)
  );

  function automatic logic [31:0] img(input int a);
    return 32'hC0DE0000 + 32'(a) * 32'h00000101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input pc_t pc, input logic [31:0] d);
    exp_t e;
    e.pc   = pc;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected instructions never presented, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every accepted instruction must be the next one the stimulus predicted.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_instr: got pc %0d data 0x%08h, none expected",
                 bus.instr_pc, bus.instr_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.instr_pc !== e.pc || bus.instr_data !== e.data) begin
          n_fail++;
          $display("FAIL instr_stream: got pc %0d data 0x%08h expected pc %0d data 0x%08h",
                   bus.instr_pc, bus.instr_data, e.pc, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    bus.load_valid     = 1'b0;
    bus.load_addr      = '0;
    bus.load_data      = '0;
    bus.load_last      = 1'b0;
    bus.reload         = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;

    // Reset with a load word offered: nothing may be written.
    tick();
    bus.load_valid = 1'b1;
    bus.load_addr  = 5'd5;
    bus.load_data  = 32'hDEADBEEF;
    #1;
    chk("reset_mem_rd", 32'(bus.mem_rd), 32'd1);
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset_load_ready", 32'(bus.load_ready), 32'd1);
    chk("reset_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("reset_instr_data", bus.instr_data, 32'd0);
    chk("reset_instr_pc", 32'(bus.instr_pc), 32'd0);
    bus.load_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Two-word program, then fetch with the consumer always ready.
    bus.instr_ready = 1'b1;
    push(5'd0, 32'h376235E0);
    push(5'd1, 32'h00000013);
    bus.load_valid = 1'b1;
    bus.load_addr  = 5'd0;
    bus.load_data  = 32'h376235E0;
    #1;
    chk("load0_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("load0_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("load0_mem_wdata", bus.mem_wdata, 32'h376235E0);
    chk("load0_load_ready", 32'(bus.load_ready), 32'd1);
    tick();
    bus.load_addr = 5'd1;
    bus.load_data = 32'h00000013;
    bus.load_last = 1'b1;
    #1;
    chk("load1_mem_addr", 32'(bus.mem_addr), 32'd1);
    chk("load1_mem_wdata", bus.mem_wdata, 32'h00000013);
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("issue_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("issue_load_ready", 32'(bus.load_ready), 32'd0);
    chk("issue_mem_rd", 32'(bus.mem_rd), 32'd1);
    chk("issue_mem_addr", 32'(bus.mem_addr), 32'd0);
    tick();
    chk("first_valid_latency", 32'(bus.instr_valid), 32'd1);
    drain("first_stream");
    bus.instr_ready = 1'b0;

    // Reload, then a full image; reload asserted again in LOAD must not matter.
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    chk("reload_load_ready", 32'(bus.load_ready), 32'd1);
    chk("reload_instr_valid", 32'(bus.instr_valid), 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus.load_valid = 1'b1;
      bus.load_addr  = 5'(a);
      bus.load_data  = img(a);
      bus.load_last  = (a == 31);
      bus.reload     = (a == 0);
      #1;
      if (a == 0) chk("reload_in_load_write", 32'(bus.mem_rd), 32'd0);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.reload     = 1'b0;
    tick();

    // Backpressure: presented word holds for 5 cycles with no write.
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.instr_valid), 32'd1);
      chk("bp_pc", 32'(bus.instr_pc), 32'd0);
      chk("bp_data", bus.instr_data, img(0));
      chk("bp_mem_rd", 32'(bus.mem_rd), 32'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) push(5'(i), img(i));
    bus.instr_ready = 1'b1;
    drain("seq_stream");
    bus.instr_ready = 1'b0;
    tick();
    tick();

    // Wrap: redirect to 31, then 31 and 0.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 5'd31;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redirect_valid_low", 32'(bus.instr_valid), 32'd0);
    push(5'd31, img(31));
    push(pc_next(5'd31), img(0));
    bus.instr_ready = 1'b1;
    tick();
    chk("redirect_valid_high", 32'(bus.instr_valid), 32'd1);
    chk("redirect_pc", 32'(bus.instr_pc), 32'd31);
    drain("wrap_stream");
    bus.instr_ready = 1'b0;
    tick();
    tick();

    // Reload + redirect + handshake together: handshake consumed, LOAD wins.
    push(5'd1, img(1));
    bus.instr_ready    = 1'b1;
    bus.reload         = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 5'd9;
    tick();
    bus.reload         = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    chk("sim_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("sim_load_ready", 32'(bus.load_ready), 32'd1);
    chk("sim_mem_addr", 32'(bus.mem_addr), 32'd0);
    tick();
    chk("sim_still_load", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.load_addr  = 5'd0;
    bus.load_data  = img(0);
    bus.load_last  = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    tick();
    chk("post_reload_pc", 32'(bus.instr_pc), 32'd0);
    tick();

    // Redirect with same-cycle handshake, then throughput over 8 cycles.
    push(5'd0, img(0));
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 5'd20;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 20; i < 28; i++) push(5'(i), img(i));
    chk("rh_valid_low", 32'(bus.instr_valid), 32'd0);
    tick();
    hs = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.instr_valid && bus.instr_ready) hs++;
      tick();
    end
    chk("throughput_8_cycles", 32'(hs), 32'(EXP_HS));
    drain("redirect_stream");
    bus.instr_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_controller.md
# imem_controller

Sequencer for the 32-entry × 32-bit instruction memory. After reset it accepts a program image over a load handshake and writes it into the memory. It then fetches instructions from a program counter and presents them to the core over a valid/ready stream. It owns the memory's `rd` line, so no other agent drives the memory.

## Interface
Parameters:
- `ADDR_W`, 5, memory address width (depth = 2^ADDR_W).
- `DATA_W`, 32, instruction width.
- `RESET_PC`, 0, first fetch address after load completes.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: load word offered.
- `load_ready` out 1: controller accepts load words.
- `load_addr` in ADDR_W: target address of the load word.
- `load_data` in DATA_W: load word.
- `load_last` in 1: marks the final load word; qualified by `load_valid`.
- `reload` in 1: return to load phase.
- `redirect_valid` in 1: pc redirect request.
- `redirect_pc` in ADDR_W: new pc value.
- `instr_valid` out 1: fetched instruction available.
- `instr_ready` in 1: consumer accepts.
- `instr_pc` out ADDR_W: address of the presented instruction.
- `instr_data` out DATA_W: presented instruction.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rd` out 1: 1 = read, 0 = write.
- `mem_rdata` in DATA_W: memory read data, combinational from `mem_addr` when `mem_rd`=1.

## Operation
States: LOAD, ISSUE, VALID.

- **Reset values:**
  - State LOAD, pc = RESET_PC.
  - `instr_valid`=0, `instr_data`=0, `instr_pc`=0.
  - `mem_rd`=1, `mem_addr`=0, `mem_wdata`=0.
  - `load_ready`=1.
- **`mem_rd` rule:** `mem_rd` is 0 only in a LOAD cycle with `load_valid`=1. In every other cycle it is 1, so the memory never sees a spurious write.
- **LOAD:**
  - `load_ready`=1.
  - On `load_valid`: `mem_addr`=`load_addr`, `mem_wdata`=`load_data`, `mem_rd`=0, and the write completes that cycle.
  - `load_valid` && `load_last`: pc ← RESET_PC, next state ISSUE.
  - `redirect_valid` and `instr_ready` are ignored.
- **ISSUE:**
  - `mem_addr`=pc, `mem_rd`=1.
  - Clock edge: `instr_data` ← `mem_rdata`, `instr_pc` ← pc, `instr_valid` ← 1, next state VALID.
- **VALID:**
  - Holds `instr_*` stable until `instr_valid` && `instr_ready`.
  - On that handshake: pc ← pc+1 modulo 2^ADDR_W (31 wraps to 0), `instr_valid` ← 0, next state ISSUE.
- **Redirect** (ISSUE or VALID):
  - pc ← `redirect_pc`, `instr_valid` ← 0, next state ISSUE.
  - Wins over a same-cycle handshake. That handshake still counts as consumed, but pc comes from the redirect.
- **Reload** (ISSUE or VALID):
  - Next state LOAD, `instr_valid` ← 0.
  - Wins over redirect and handshake.
- **`reload` in LOAD:** no effect.
- **`rst_n` mid-operation:** forces reset values immediately. A write cycle interrupted by reset must not corrupt memory, which is why the reset value of `mem_rd` is 1.

## Timing
- LOAD: one write per cycle; `load_ready` is never deasserted while in LOAD.
- `load_last` accepted at edge N → ISSUE in cycle N+1 → `instr_valid`=1 in cycle N+2.
- Base throughput: one instruction per 2 cycles.
- Redirect at edge N → `instr_valid`=0 in cycle N+1 → redirected instruction valid in cycle N+2.

## Configuration
- `IMEM_CTRL_PREFETCH_EN` defined:
  - In VALID, the memory is read at pc+1 and a one-entry prefetch buffer is filled.
  - On handshake, the buffered word is presented at the next cycle with `instr_valid` held at 1.
  - Sustained throughput: one instruction per cycle.
  - Redirect or reload invalidates the buffer.
  - Wrap rule applies to pc+1.
- Undefined: no buffer; 2-cycle throughput as above.
- Port list is identical in both builds.

## Structure
- **`imem_ctrl_pkg`:**
  - State enum (LOAD, ISSUE, VALID).
  - Default ADDR_W, DATA_W and RESET_PC constants.
  - pc type.
- **Sub-module `imem_prefetch_buf`:**
  - One-entry data+pc register with valid and flush.
  - Instantiated only under `IMEM_CTRL_PREFETCH_EN`.
- Memory is external; the bench instantiates `instruction_memory` on the `mem_*` ports.

## Test plan
- **Reset:** hold `rst_n`=0 → all outputs at reset values, `mem_rd`=1, `load_ready`=1.
- **Load then fetch:**
  - Load addr 0 = 0x376235E0, addr 1 = 0x00000013 (last).
  - With `instr_ready`=1: `instr_valid` rises 2 cycles after last; pc 0 shows 0x376235E0, then pc 1 shows 0x00000013.
- **Wrap:**
  - Redirect to 31, then two handshakes → `instr_pc` 31, then 0.
- **Backpressure:**
  - Hold `instr_ready`=0 for 5 cycles → `instr_data`/`instr_pc` stable and `mem_rd`=1 throughout.
- **Simultaneous events:**
  - `reload` + `redirect_valid` + handshake in the same cycle → state LOAD, `instr_valid`=0 next cycle, pc unchanged by the redirect.
- **Prefetch throughput** (`IMEM_CTRL_PREFETCH_EN`, `instr_ready`=1):
  - 8 consecutive handshakes in 8 cycles.
  - Redirect mid-stream → no stale buffered word is presented.
